// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared byte-enabled data memory: fetch (port 0) and load/store (port 1).
// Optional build macro MEM_ARB_FIXED_PRIO_EN: port 1 always wins, no round-robin pointer.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_ack,
    output logic              i_err,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_ack,
    output logic              d_err,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned WADDR_W = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e state_q, state_d;

    logic               owner_q, owner_d;
    logic               we_q, we_d;
    logic [2:0]         funct_q, funct_d;
    logic [1:0]         lane_q, lane_d;
    logic               err_q, err_d;
    logic               mem_en_q, mem_en_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic [WADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               i_ack_q, i_ack_d, i_err_q, i_err_d;
    logic               d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [31:0]        i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

    logic               grant_c;
    logic               sel_d_c;
    logic [ADDR_W-1:0]  sel_addr_c;
    logic               sel_we_c;
    logic [2:0]         sel_funct_c;
    logic               sel_err_c;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c;
    logic [7:0]         byte_c;
    logic [15:0]        half_c;
    logic [31:0]        load_c;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign sel_d_c = d_req;
`else
    // last_q = port served most recently; reset value 0 makes port 1 win the first tie
    logic last_q, last_d;
    assign sel_d_c = d_req && (!i_req || !last_q);
`endif

    assign grant_c = (state_q == IDLE) && rst_n && (i_req || d_req);
    assign i_gnt   = grant_c && !sel_d_c;
    assign d_gnt   = grant_c && sel_d_c;

    // Operands of the winning port; a fetch behaves as an aligned LW
    always_comb begin
        sel_addr_c  = sel_d_c ? d_addr : i_addr;
        sel_we_c    = sel_d_c && d_we;
        sel_funct_c = sel_d_c ? d_funct : 3'b010;
        sel_err_c   = 1'b0;
        if (sel_we_c) begin
            case (sel_funct_c[1:0])
                2'b00:   sel_err_c = 1'b0;
                2'b01:   sel_err_c = sel_addr_c[0];
                2'b10:   sel_err_c = (sel_addr_c[1:0] != 2'b00);
                default: sel_err_c = 1'b1;
            endcase
        end else begin
            case (sel_funct_c)
                3'b000, 3'b100: sel_err_c = 1'b0;
                3'b001, 3'b101: sel_err_c = sel_addr_c[0];
                3'b010:         sel_err_c = (sel_addr_c[1:0] != 2'b00);
                default:        sel_err_c = 1'b1;
            endcase
        end
    end

    // Store lane steering
    always_comb begin
        be_c    = 4'hF;
        wdata_c = d_wdata;
        case (sel_funct_c[1:0])
            2'b00: begin
                be_c    = 4'(4'b0001 << sel_addr_c[1:0]);
                wdata_c = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = 4'(4'b0011 << sel_addr_c[1:0]);
                wdata_c = {2{d_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'hF;
                wdata_c = d_wdata;
            end
        endcase
    end

    // Load lane select and extension
    always_comb begin
        case (lane_q)
            2'd0:    byte_c = mem_rdata[7:0];
            2'd1:    byte_c = mem_rdata[15:8];
            2'd2:    byte_c = mem_rdata[23:16];
            default: byte_c = mem_rdata[31:24];
        endcase
        half_c = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct_q)
            3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
            3'b100:  load_c = {24'h000000, byte_c};
            3'b001:  load_c = {{16{half_c[15]}}, half_c};
            3'b101:  load_c = {16'h0000, half_c};
            default: load_c = mem_rdata;
        endcase
        if (err_q || we_q) begin
            load_c = 32'h0000_0000;
        end
    end

    // Next-state and registered outputs
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        funct_d     = funct_q;
        lane_d      = lane_q;
        err_d       = err_q;
        mem_en_d    = 1'b0;
        mem_be_d    = 4'h0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ack_d     = 1'b0;
        i_err_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_c) begin
                    state_d     = ISSUE;
                    owner_d     = sel_d_c;
                    we_d        = sel_we_c;
                    funct_d     = sel_funct_c;
                    lane_d      = sel_addr_c[1:0];
                    err_d       = sel_err_c;
                    mem_en_d    = !sel_err_c;
                    mem_be_d    = (sel_we_c && !sel_err_c) ? be_c : 4'h0;
                    mem_addr_d  = sel_addr_c[ADDR_W-1:2];
                    mem_wdata_d = sel_we_c ? wdata_c : 32'h0000_0000;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                state_d = RESP;
                if (owner_q) begin
                    d_ack_d   = 1'b1;
                    d_err_d   = err_q;
                    d_rdata_d = load_c;
                end else begin
                    i_ack_d   = 1'b1;
                    i_err_d   = err_q;
                    i_rdata_d = load_c;
                end
            end
            RESP: begin
                state_d = IDLE;
`ifndef MEM_ARB_FIXED_PRIO_EN
                last_d  = owner_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            funct_q     <= 3'b000;
            lane_q      <= 2'b00;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
            i_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            i_rdata_q   <= 32'h0000_0000;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= 32'h0000_0000;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            funct_q     <= funct_d;
            lane_q      <= lane_d;
            err_q       <= err_d;
            mem_en_q    <= mem_en_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            i_err_q     <= i_err_d;
            i_rdata_q   <= i_rdata_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ack     = i_ack_q;
    assign i_err     = i_err_q;
    assign i_rdata   = i_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;

endmodule
